fdc_host_bridge: RTL and testbench

FDC_HOST_BRIDGE -- requirements
Module: fdc_host_bridge

---
 rtl/fdc_host_bridge.sv | 136 +++++++++++++
 tb/tb_fdc_host_bridge.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fdc_host_bridge.sv
// fdc_host_bridge: CPU-to-wd1793 request bridge with clock-enable divider, strobe sequencer,
// $FF40 drive control register and per-drive mount state.
module fdc_host_bridge #(
  parameter int NUM_DRIVES = 2,
  parameter int CE_DIV     = 6
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    HOST_RD,
  input  logic                    HOST_WR,
  input  logic [1:0]              ADDRESS,
  input  logic [7:0]              DATA_IN,
  input  logic                    FF40_WR,
  input  logic                    FF40_RD,
  input  logic                    BYPASS,
  output logic                    FDC_CE,
  output logic [NUM_DRIVES-1:0]   FDC_RD,
  output logic [NUM_DRIVES-1:0]   FDC_WR,
  output logic [1:0]              FDC_ADDR,
  output logic [7:0]              FDC_DIN,
  input  logic [8*NUM_DRIVES-1:0] FDC_DOUT,
  input  logic [NUM_DRIVES-1:0]   FDC_DRQ,
  input  logic [NUM_DRIVES-1:0]   FDC_INTRQ,
  output logic [7:0]              DATA_OUT,
  output logic [7:0]              FF40_Q,
  output logic                    HALT,
  output logic                    NMI,
  output logic [1:0]              DRIVE_IDX,
  output logic                    SIDE,
  input  logic [NUM_DRIVES-1:0]   img_mounted,
  input  logic                    img_readonly,
  input  logic [63:0]             img_size,
  output logic [NUM_DRIVES-1:0]   DRIVE_WP,
  output logic [NUM_DRIVES-1:0]   DRIVE_READY,
  output logic [NUM_DRIVES-1:0]   DOUBLE_SIDED
);
  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH, HOLD} state_t;
  state_t state;
  logic [5:0] cnt;
  logic [2:0] rd_s, wr_s;
  logic rd_rise, wr_rise, req_latch, busy, is_wr;
  logic [1:0] chan, sel_k;
  logic sel_ok, intrq_sel, halt_en, density, precomp, motor, ds_size;
  logic [2:0] sel;
  logic [3:0] drq_p, intrq_p;
  logic [31:0] dout_p;
  // mount state survives RESET_N so mounted images persist across CPU resets
  logic [NUM_DRIVES-1:0] mnt_q = '0, wp_q = '0, rdy_q = '0, ds_q = '0;

  assign FDC_CE    = cnt == 6'(CE_DIV - 1);
  assign rd_rise   = rd_s[1] & ~rd_s[2];
  assign wr_rise   = wr_s[1] & ~wr_s[2];
  assign req_latch = (rd_s[0] & ~rd_s[1]) | (wr_s[0] & ~wr_s[1]);
  assign drq_p     = 4'(FDC_DRQ);
  assign intrq_p   = 4'(FDC_INTRQ);
  assign dout_p    = 32'(FDC_DOUT);
  assign intrq_sel = intrq_p[DRIVE_IDX];
  assign sel_k     = DATA_IN[1] ? 2'd1 : DATA_IN[2] ? 2'd2 : 2'd0;
  assign sel_ok    = $onehot(DATA_IN[2:0]) && int'(sel_k) < NUM_DRIVES;
  assign ds_size   = img_size > 64'd368600 && img_size < 64'd740000;
  assign FF40_Q    = {halt_en, SIDE, density, precomp, motor, sel};
  assign HALT      = halt_en & ~drq_p[DRIVE_IDX];
  assign NMI       = density & intrq_p[DRIVE_IDX];
  assign DATA_OUT  = FF40_RD ? FF40_Q : dout_p[{DRIVE_IDX, 3'b000} +: 8];
  assign DRIVE_WP     = wp_q;
  assign DRIVE_READY  = rdy_q;
  assign DOUBLE_SIDED = ds_q;

  always_comb begin
    busy   = !BYPASS && (state == ACTIVE || state == FLUSH);
    FDC_WR = (busy && is_wr) ? NUM_DRIVES'(1) << chan : '0;
    // the read strobe also follows the synchronized request so read data is visible early
    FDC_RD = ((busy && !is_wr) ? NUM_DRIVES'(1) << chan : '0)
           | ((!BYPASS && rd_s[1]) ? NUM_DRIVES'(1) << DRIVE_IDX : '0);
  end

  always_ff @(negedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      cnt      <= '0;
      rd_s     <= '0;
      wr_s     <= '0;
      FDC_ADDR <= '0;
      FDC_DIN  <= '0;
    end else begin
      cnt  <= FDC_CE ? '0 : cnt + 6'd1;
      rd_s <= {rd_s[1:0], HOST_RD & ~BYPASS};
      wr_s <= {wr_s[1:0], HOST_WR & ~BYPASS};
      if (req_latch) begin
        FDC_ADDR <= ADDRESS;
        FDC_DIN  <= DATA_IN;
      end
    end

  always_ff @(negedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      state <= IDLE;
      is_wr <= 1'b0;
      chan  <= '0;
    end else if (BYPASS) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (rd_rise | wr_rise) begin
          state <= ACTIVE;
          is_wr <= wr_rise;
          chan  <= DRIVE_IDX;
        end
        ACTIVE: if (FDC_CE) state <= FLUSH;
        FLUSH: state <= HOLD;
        HOLD: if (!rd_s[1] && !wr_s[1]) state <= IDLE;
        default: state <= IDLE;
      endcase
    end

  always_ff @(negedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      {halt_en, SIDE, density, precomp, motor, sel} <= '0;
      DRIVE_IDX <= '0;
    end else begin
      if (FF40_WR) begin
        {SIDE, density, precomp, motor, sel} <= DATA_IN[6:0];
        if (sel_ok) DRIVE_IDX <= sel_k;
      end
      halt_en <= intrq_sel ? 1'b0 : FF40_WR ? DATA_IN[7] : halt_en;
    end

  always_ff @(negedge CLK) begin
    mnt_q <= img_mounted;
    for (int i = 0; i < NUM_DRIVES; i++)
      if (mnt_q[i] && !img_mounted[i]) begin
        wp_q[i]  <= img_readonly;
        rdy_q[i] <= 1'b1;
        ds_q[i]  <= ds_size;
      end
  end
endmodule

// File: tb/tb_fdc_host_bridge.sv
// tb_fdc_host_bridge: randomized scoreboard bench for fdc_host_bridge against a
// transaction-level reference model.
module tb_fdc_host_bridge;
  localparam int N  = 2;
  localparam int CE = 6;

  logic CLK = 0, RESET_N = 0, HOST_RD = 0, HOST_WR = 0, FF40_WR = 0, FF40_RD = 0, BYPASS = 0;
  logic img_readonly = 0;
  logic [1:0] ADDRESS = '0;
  logic [7:0] DATA_IN = '0;
  logic [8*N-1:0] FDC_DOUT = '0;
  logic [N-1:0] FDC_DRQ = '0, FDC_INTRQ = '0, img_mounted = '0;
  logic [63:0] img_size = '0;
  logic FDC_CE, HALT, NMI, SIDE;
  logic [N-1:0] FDC_RD, FDC_WR, DRIVE_WP, DRIVE_READY, DOUBLE_SIDED;
  logic [1:0] FDC_ADDR, DRIVE_IDX;
  logic [7:0] FDC_DIN, DATA_OUT, FF40_Q;

  fdc_host_bridge #(.NUM_DRIVES(N), .CE_DIV(CE)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .HOST_RD(HOST_RD), .HOST_WR(HOST_WR), .ADDRESS(ADDRESS),
    .DATA_IN(DATA_IN), .FF40_WR(FF40_WR), .FF40_RD(FF40_RD), .BYPASS(BYPASS), .FDC_CE(FDC_CE),
    .FDC_RD(FDC_RD), .FDC_WR(FDC_WR), .FDC_ADDR(FDC_ADDR), .FDC_DIN(FDC_DIN), .FDC_DOUT(FDC_DOUT),
    .FDC_DRQ(FDC_DRQ), .FDC_INTRQ(FDC_INTRQ), .DATA_OUT(DATA_OUT), .FF40_Q(FF40_Q), .HALT(HALT),
    .NMI(NMI), .DRIVE_IDX(DRIVE_IDX), .SIDE(SIDE), .img_mounted(img_mounted),
    .img_readonly(img_readonly), .img_size(img_size), .DRIVE_WP(DRIVE_WP),
    .DRIVE_READY(DRIVE_READY), .DOUBLE_SIDED(DOUBLE_SIDED)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic       wr;
    logic [1:0] ch;
    logic [1:0] addr;
    logic [7:0] din;
  } txn_t;
  txn_t q_txn[$];
  logic [9:0] q_rd[$];

  // reference model: control register, selected drive and mounted-image state
  logic m_halt = 0, m_side = 0, m_dens = 0, m_pre = 0, m_mot = 0, hit = 0;
  logic [2:0] m_sel = '0;
  logic [1:0] m_idx = '0;
  logic [N-1:0] m_wp = '0, m_rdy = '0, m_ds = '0, m_mnt = '0;

  function automatic logic [7:0] m_q();
    return {m_halt, m_side, m_dens, m_pre, m_mot, m_sel};
  endfunction

  always @(negedge CLK) begin
    if (!RESET_N) begin
      {m_halt, m_side, m_dens, m_pre, m_mot, m_sel} = '0;
      m_idx = '0;
    end else begin
      hit = FDC_INTRQ[m_idx];
      if (FF40_WR) begin
        {m_side, m_dens, m_pre, m_mot, m_sel} = DATA_IN[6:0];
        m_halt = DATA_IN[7];
        for (int k = 0; k < N; k++)
          if (DATA_IN[2:0] == 3'(1 << k)) m_idx = 2'(k);
      end
      if (hit) m_halt = 0;
    end
    for (int i = 0; i < N; i++)
      if (m_mnt[i] && !img_mounted[i]) begin
        m_wp[i]  = img_readonly;
        m_rdy[i] = 1'b1;
        m_ds[i]  = img_size > 64'd368600 && img_size < 64'd740000;
      end
    m_mnt = img_mounted;
  end

  // monitor: samples on the posedge, away from the DUT's negedge updates
  logic [N-1:0] prev_rd = '0, prev_wr = '0, oh;
  int ce_gap = 0, ce_n = 0, since = 0;
  bit ce_seen = 0;
  logic [9:0] rd_exp;

  always @(posedge CLK) begin
    check("mount_state", {DRIVE_WP, DRIVE_READY, DOUBLE_SIDED}, {m_wp, m_rdy, m_ds});
    if (!RESET_N) begin
      ce_seen = 0;
      prev_rd = '0;
      prev_wr = '0;
    end else begin
      ce_gap++;
      if (FDC_CE) begin
        if (ce_seen) check("ce_period", ce_gap, CE);
        ce_seen = 1;
        ce_gap = 0;
      end
      if ({FDC_WR, FDC_RD} != '0 && {prev_wr, prev_rd} == '0) begin
        if (q_txn.size() == 0) check("strobe_unexpected", {FDC_WR, FDC_RD}, 0);
        else begin
          txn_t t;
          t = q_txn.pop_front();
          oh = N'(1) << t.ch;
          check("strobe_sel", {FDC_WR, FDC_RD}, t.wr ? {oh, {N{1'b0}}} : {{N{1'b0}}, oh});
          check("fdc_addr", FDC_ADDR, t.addr);
          if (t.wr) check("fdc_din", FDC_DIN, t.din);
        end
      end
      if (FDC_WR != '0) begin
        if (prev_wr == '0) begin
          ce_n = 0;
          since = 0;
        end else check("wr_stable", FDC_WR, prev_wr);
        if (FDC_CE) begin
          ce_n++;
          since = 0;
        end else since++;
      end else if (prev_wr != '0) begin
        check("wr_ce_count", ce_n, 1);
        check("wr_flush_tail", since, 1);
      end
      check("halt", HALT, m_halt & ~FDC_DRQ[m_idx]);
      check("nmi", NMI, m_dens & FDC_INTRQ[m_idx]);
      check("drive_idx", DRIVE_IDX, m_idx);
      check("ff40_q", FF40_Q, m_q());
      check("side", SIDE, m_side);
      if (FF40_RD) begin
        if (q_rd.size() == 0) check("ff40_rd_unexpected", DATA_OUT, 0);
        else begin
          rd_exp = q_rd.pop_front();
          check("ff40_read_idx", DRIVE_IDX, rd_exp[9:8]);
          check("ff40_read_data", DATA_OUT, rd_exp[7:0]);
        end
      end else check("data_out_fdc", DATA_OUT, FDC_DOUT[m_idx*8 +: 8]);
      prev_wr = FDC_WR;
      prev_rd = FDC_RD;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic ff40_write(input logic [7:0] d);
    DATA_IN = d;
    FF40_WR = 1;
    tick();
    FF40_WR = 0;
  endtask

  task automatic ff40_read(input logic [9:0] e);
    q_rd.push_back(e);
    FF40_RD = 1;
    tick();
    FF40_RD = 0;
  endtask

  task automatic host_xfer(input bit wr, input logic [1:0] ch, input logic [1:0] a,
                           input logic [7:0] d, input int hold, input bit mid_ff40);
    txn_t t;
    t.wr = wr; t.ch = ch; t.addr = a; t.din = d;
    q_txn.push_back(t);
    ADDRESS = a;
    DATA_IN = d;
    if (wr) HOST_WR = 1; else HOST_RD = 1;
    for (int c = 0; c < hold; c++) begin
      if (c == 4) begin
        ADDRESS = ~a;
        DATA_IN = ~d;
      end
      if (mid_ff40 && c == 5) ff40_write(8'($urandom));
      tick();
    end
    HOST_WR = 0;
    HOST_RD = 0;
    tick(14);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int strobes, w, hold;
    bit wr;
    tick(3);
    check("rst_ce", FDC_CE, 0);
    check("rst_strobes", {FDC_WR, FDC_RD}, 0);
    check("rst_halt", HALT, 0);
    check("rst_nmi", NMI, 0);
    check("rst_ff40_q", FF40_Q, 0);
    check("rst_drive_idx", DRIVE_IDX, 0);
    RESET_N = 1;
    tick(20);

    img_size = 64'd368640;
    img_readonly = 1;
    img_mounted = 2'b01;
    tick(2);
    img_mounted = '0;
    tick(2);
    check("mount_ds0", DOUBLE_SIDED[0], 1);
    check("mount_wp0", DRIVE_WP[0], 1);
    check("mount_ready0", DRIVE_READY[0], 1);
    RESET_N = 0;
    tick(3);
    RESET_N = 1;
    tick(2);
    check("mount_kept", {DRIVE_WP[0], DRIVE_READY[0], DOUBLE_SIDED[0]}, 3'b111);

    FDC_DOUT = 16'hC3A5;
    ff40_write(8'h8A);
    ff40_read({2'd1, 8'h8A});
    host_xfer(1, 2'd1, 2'd3, 8'h55, 40, 0);

    ff40_write(8'h07);
    ff40_read({2'd1, 8'h07});

    FDC_DRQ = '0;
    ff40_write(8'h81);
    check("halt_set", HALT, 1);
    DATA_IN = 8'h81;
    FF40_WR = 1;
    FDC_INTRQ = 2'b01;
    tick();
    FF40_WR = 0;
    FDC_INTRQ = '0;
    check("halt_clear_wins", HALT, 0);
    ff40_read({2'd0, 8'h01});

    BYPASS = 1;
    tick();
    HOST_RD = 1;
    strobes = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if ({FDC_WR, FDC_RD} != '0) strobes++;
    end
    HOST_RD = 0;
    check("bypass_strobes", strobes, 0);
    ff40_write(8'h22);
    ff40_read({2'd1, 8'h22});
    tick(3);
    BYPASS = 0;
    tick(5);

    q_txn.push_back('{1'b1, m_idx, 2'd2, 8'h3C});
    ADDRESS = 2'd2;
    DATA_IN = 8'h3C;
    HOST_WR = 1;
    w = 0;
    while (FDC_WR == '0 && w < 40) begin
      tick();
      w++;
    end
    check("rst_mid_window_seen", FDC_WR != '0, 1);
    RESET_N = 0;
    #1;
    check("rst_mid_drop", {FDC_WR, FDC_RD}, 0);
    HOST_WR = 0;
    tick(3);
    RESET_N = 1;
    tick(20);

    for (int n = 0; n < 40; n++) begin
      FDC_DOUT = 16'($urandom);
      FDC_DRQ = N'($urandom);
      ff40_write(8'($urandom));
      FDC_INTRQ = N'($urandom);
      tick();
      FDC_INTRQ = '0;
      tick();
      ff40_read({m_idx, m_q()});
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 5))
          0: img_size = 64'd368600;
          1: img_size = 64'd368601;
          2: img_size = 64'd739999;
          3: img_size = 64'd740000;
          4: img_size = 64'd184320;
          default: img_size = 64'($urandom);
        endcase
        img_readonly = 1'($urandom);
        img_mounted = N'(1) << $urandom_range(0, N - 1);
        tick(2);
        img_mounted = '0;
        tick(2);
      end
      wr = 1'($urandom);
      hold = $urandom_range(2, 30);
      host_xfer(wr, m_idx, 2'($urandom), 8'($urandom), hold, wr && hold >= 8 && $urandom_range(0, 1) == 1);
    end
    tick(30);
    check("txn_queue_drained", q_txn.size(), 0);
    check("rd_queue_drained", q_rd.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
